// File: rtl/imem_enc_pkg.sv
// Shared definitions for the instruction-memory program encoder.
//   - kind_e   : instruction class presented on in_kind
//   - OPC_*    : RV32 major opcodes (same values the opcode decoder matches)
//   - state_e  : loader FSM states
//   - HALT_WORD: encoding of the custom HALT instruction
//   - fits_signed(): immediate range helper used when IMEM_ENC_RANGE_CHECK_EN is defined
package imem_enc_pkg;

    typedef enum logic [3:0] {
        KindR      = 4'd0,
        KindIImm   = 4'd1,
        KindLoad   = 4'd2,
        KindStore  = 4'd3,
        KindBranch = 4'd4,
        KindLui    = 4'd5,
        KindJal    = 4'd6,
        KindJalr   = 4'd7,
        KindHalt   = 4'd8
    } kind_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_HALT   = 7'b1111111;

    localparam logic [31:0] HALT_WORD = 32'h0000_007F;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDone  = 2'd2,
        StError = 2'd3
    } state_e;

    // True when v is a sign-extended value of the given width: every bit from
    // bits-1 upward is a copy of the sign.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = v >> (bits - 1);
        return (hi == 32'h0) || (hi == (32'hFFFF_FFFF >> (bits - 1)));
    endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational RV32 instruction packer.
//   kind_i/rd_i/rs1_i/rs2_i/funct3_i/funct7b5_i/imm_i : instruction fields
//   word_o  : packed 32-bit instruction (fields unused by the format are 0)
//   legal_o : kind is one of the nine supported classes and, when
//             IMEM_ENC_RANGE_CHECK_EN is defined, the immediate is in range
module instr_field_encoder
    import imem_enc_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    kind_e kind;
    logic  kind_ok;
    logic  range_ok;

    assign kind = kind_e'(kind_i);

    always_comb begin
        word_o  = '0;
        kind_ok = 1'b1;
        case (kind)
            KindR:      word_o = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OPC_R};
            KindIImm: begin
                // srli/srai: shamt in 24:20, bit 30 selects arithmetic shift
                if (funct3_i == 3'b101) begin
                    word_o = {1'b0, funct7b5_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i,
                              OPC_I_IMM};
                end else begin
                    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_I_IMM};
                end
            end
            KindLoad:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
            KindStore:  word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
            KindBranch: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                  imm_i[4:1], imm_i[11], OPC_BRANCH};
            KindLui:    word_o = {imm_i[31:12], rd_i, OPC_LUI};
            KindJal:    word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
            KindJalr:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_JALR};
            KindHalt:   word_o = HALT_WORD;
            default:    kind_ok = 1'b0;
        endcase
    end

`ifdef IMEM_ENC_RANGE_CHECK_EN
    always_comb begin
        range_ok = 1'b1;
        case (kind)
            KindIImm, KindLoad, KindJalr, KindStore: range_ok = fits_signed(imm_i, 12);
            KindBranch: range_ok = fits_signed(imm_i, 13) && !imm_i[0];
            KindJal:    range_ok = fits_signed(imm_i, 21) && !imm_i[0];
            KindLui:    range_ok = (imm_i[11:0] == 12'h000);
            default:    range_ok = 1'b1;
        endcase
    end
`else
    // Out-of-range bits are truncated by the packing above.
    assign range_ok = 1'b1;
`endif

    assign legal_o = kind_ok && range_ok;

endmodule

// File: rtl/imem_program_encoder.sv
// Sequential instruction encoder and instruction-memory loader.
// Accepts instruction beats over valid/ready, encodes them and writes the
// words to consecutive word addresses starting at 0 after each start pulse.
// Optional macro: IMEM_ENC_RANGE_CHECK_EN (immediate range checking).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : begin/restart a load at address 0 (wins over a beat)
//   in_valid/in_ready     : beat handshake; in_ready is high only in LOAD
//   in_kind..in_imm       : instruction fields
//   imem_we/addr/wdata    : registered write port, one cycle after acceptance
//   busy, done, err       : in LOAD, HALT written, load aborted (sticky)
//   count                 : words written since the last start
module imem_program_encoder
    import imem_enc_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        is_halt;
    logic        last_slot;

    instr_field_encoder u_enc (
        .kind_i     (in_kind),
        .rd_i       (in_rd),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .funct3_i   (in_funct3),
        .funct7b5_i (in_funct7b5),
        .imm_i      (in_imm),
        .word_o     (enc_word),
        .legal_o    (enc_legal)
    );

    assign is_halt   = (in_kind == KindHalt);
    // The final slot is reserved for HALT so the pointer never wraps.
    assign last_slot = (ptr_q == ADDR_W'(IMEM_DEPTH - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        if (start) begin
            state_d = StLoad;
            ptr_d   = '0;
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        if (!enc_legal || (last_slot && !is_halt)) begin
                            state_d = StError;
                            err_d   = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdata_d = enc_word;
                            ptr_d   = ptr_q + 1'b1;
                            count_d = count_q + 1'b1;
                            if (is_halt) begin
                                state_d = StDone;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Derived from the state register only, so never combinational on in_valid.
    assign in_ready   = (state_q == StLoad);
    assign busy       = (state_q == StLoad);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_imem_program_encoder.sv
module tb_imem_program_encoder;

    localparam int DEPTH  = 256;
    localparam int SDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, in_valid, in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_imm;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err;
    logic [8:0]  count;

    logic        s_start, s_in_valid, s_in_ready;
    logic [3:0]  s_in_kind;
    logic [4:0]  s_in_rd, s_in_rs1, s_in_rs2;
    logic [2:0]  s_in_funct3;
    logic        s_in_funct7b5;
    logic [31:0] s_in_imm;
    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic        s_busy, s_done, s_err;
    logic [2:0]  s_count;

    int checks = 0;
    int errors = 0;

    // Reference model of the big instance: words written, loading/done/err flags.
    int m_count;
    bit m_loading, m_done, m_err;

    always #5 clk = ~clk;

    imem_program_encoder #(.IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    imem_program_encoder #(.IMEM_DEPTH(SDEPTH)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_kind(s_in_kind), .in_rd(s_in_rd), .in_rs1(s_in_rs1),
        .in_rs2(s_in_rs2), .in_funct3(s_in_funct3), .in_funct7b5(s_in_funct7b5),
        .in_imm(s_in_imm), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .busy(s_busy), .done(s_done), .err(s_err),
        .count(s_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Field-by-field arithmetic placement of each RV32 format.
    function automatic logic [31:0] ref_word(input logic [3:0] k, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [2:0] f3, input logic f7,
                                             input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] rdp, rs1p, rs2p, f3p;
        rdp  = 32'(rd) << 7;
        f3p  = 32'(f3) << 12;
        rs1p = 32'(rs1) << 15;
        rs2p = 32'(rs2) << 20;
        case (k)
            4'd0: w = 32'h33 | rdp | f3p | rs1p | rs2p | (32'(f7) << 30);
            4'd1: begin
                if (f3 == 3'd5) w = 32'h13 | rdp | f3p | rs1p | ((imm & 32'h1F) << 20)
                                    | (32'(f7) << 30);
                else            w = 32'h13 | rdp | f3p | rs1p | ((imm & 32'hFFF) << 20);
            end
            4'd2: w = 32'h03 | rdp | f3p | rs1p | ((imm & 32'hFFF) << 20);
            4'd3: w = 32'h23 | ((imm & 32'h1F) << 7) | f3p | rs1p | rs2p
                      | (((imm >> 5) & 32'h7F) << 25);
            4'd4: w = 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                      | f3p | rs1p | rs2p | (((imm >> 5) & 32'h3F) << 25)
                      | (((imm >> 12) & 32'h1) << 31);
            4'd5: w = 32'h37 | rdp | (imm & 32'hFFFF_F000);
            4'd6: w = 32'h6F | rdp | (((imm >> 12) & 32'hFF) << 12)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 20) & 32'h1) << 31);
            4'd7: w = 32'h67 | rdp | f3p | rs1p | ((imm & 32'hFFF) << 20);
            4'd8: w = 32'h7F;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic bit ref_legal(input logic [3:0] k, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if (k > 4'd8) return 1'b0;
`ifdef IMEM_ENC_RANGE_CHECK_EN
        case (k)
            4'd1, 4'd2, 4'd3, 4'd7: return (s >= -2048) && (s <= 2047);
            4'd4: return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
            4'd6: return (s >= -(1 << 20)) && (s < (1 << 20)) && (imm[0] == 1'b0);
            4'd5: return imm[11:0] == 12'h0;
            default: return 1'b1;
        endcase
`else
        return (s == s) || 1'b1;
`endif
    endfunction

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b0;
        cyc();
        start     = 1'b0;
        m_count   = 0;
        m_loading = 1'b1;
        m_done    = 1'b0;
        m_err     = 1'b0;
        checks++;
        if ({in_ready, busy, done, err} !== 4'b1100 || count !== 9'd0) begin
            errors++;
            $display("FAIL start_state: got rdy/busy/done/err=%b count=%0d expected 1100 count=0",
                     {in_ready, busy, done, err}, count);
        end
    endtask

    // One beat on the big instance, checked against the model one cycle later.
    task automatic beat(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm, output logic [31:0] got);
        bit          exp_we;
        logic [31:0] exp_w;
        int          exp_addr;
        in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7b5 = f7; in_imm = imm;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        exp_we   = 1'b0;
        exp_w    = ref_word(k, rd, rs1, rs2, f3, f7, imm);
        exp_addr = m_count;
        if (m_loading) begin
            if (ref_legal(k, imm) && (k == 4'd8 || m_count < DEPTH - 1)) begin
                exp_we = 1'b1;
                m_count++;
                if (k == 4'd8) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end else begin
                m_loading = 1'b0;
                m_err     = 1'b1;
            end
        end
        got = imem_wdata;
        checks++;
        if (imem_we !== exp_we) begin
            errors++;
            $display("FAIL beat_we: kind=%0d got %b expected %b", k, imem_we, exp_we);
        end
        if (exp_we) begin
            checks++;
            if (imem_addr !== 8'(exp_addr) || imem_wdata !== exp_w) begin
                errors++;
                $display("FAIL beat_write: kind=%0d got addr=%0d data=%h expected addr=%0d data=%h",
                         k, imem_addr, imem_wdata, exp_addr, exp_w);
            end
        end
        checks++;
        if (count !== 9'(m_count) || {in_ready, busy, done, err} !==
            {m_loading, m_loading, m_done, m_err}) begin
            errors++;
            $display("FAIL beat_status: got count=%0d rdy/busy/done/err=%b expected %0d %b",
                     count, {in_ready, busy, done, err}, m_count,
                     {m_loading, m_loading, m_done, m_err});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7b5 = 1'b0; in_imm = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_kind = '0; s_in_rd = '0; s_in_rs1 = '0;
        s_in_rs2 = '0; s_in_funct3 = '0; s_in_funct7b5 = 1'b0; s_in_imm = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        m_count = 0; m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0;
        checks++;
        if ({in_ready, imem_we, busy, done, err} !== 5'b0 || imem_addr !== 8'd0 ||
            imem_wdata !== 32'd0 || count !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b addr=%h data=%h count=%0d expected all 0",
                     {in_ready, imem_we, busy, done, err}, imem_addr, imem_wdata, count);
        end
        checks++;
        if ({s_in_ready, s_imem_we, s_busy, s_done, s_err} !== 5'b0 || s_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_small: got flags=%b count=%0d expected 0",
                     {s_in_ready, s_imem_we, s_busy, s_done, s_err}, s_count);
        end
    endtask

    task automatic test_addi();
        logic [31:0] w;
        do_start();
        beat(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, w);
        checks++;
        if (w !== 32'h0050_0093) begin
            errors++;
            $display("FAIL addi_word: got %h expected 00500093", w);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[6];
        logic [31:0] exp_w[6];
        exp_w = '{32'h0020_81B3, 32'h0020_A423, 32'hFE20_8EE3, 32'h0080_00EF,
                  32'h1234_52B7, 32'h0000_007F};
        do_start();
        beat(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, w[0]);
        beat(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, w[1]);
        beat(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, w[2]);
        beat(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, w[3]);
        beat(4'd5, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, w[4]);
        beat(4'd8, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, w[5]);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h expected %h", i, w[i], exp_w[i]);
            end
        end
        cyc();
        checks++;
        if (imem_we !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0 || count !== 9'd6) begin
            errors++;
            $display("FAIL done_hold: got we=%b done=%b rdy=%b count=%0d expected 0 1 0 6",
                     imem_we, done, in_ready, count);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        do_start();
        beat(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7, w);
        beat(4'd1, 5'd3, 5'd2, 5'd0, 3'd0, 1'b0, 32'd9, w);
        beat(4'd12, 5'd3, 5'd2, 5'd0, 3'd0, 1'b0, 32'd9, w);
        checks++;
        if (err !== 1'b1 || count !== 9'd2 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL illegal_kind: got err=%b count=%0d we=%b expected 1 2 0",
                     err, count, imem_we);
        end
        beat(4'd1, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, w);
        do_start();
        beat(4'd1, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, w);
        checks++;
        if (imem_addr !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL restart_addr: got addr=%0d err=%b expected 0 0", imem_addr, err);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] imm;
        for (int pass = 0; pass < 2; pass++) begin
            s_start = 1'b1;
            cyc();
            s_start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                imm = 32'($urandom_range(0, 2047));
                s_in_kind = (pass == 1 && i == 3) ? 4'd8 : 4'd1;
                s_in_rd = 5'(i + 1); s_in_rs1 = 5'd0; s_in_rs2 = 5'd0;
                s_in_funct3 = 3'd0; s_in_funct7b5 = 1'b0; s_in_imm = imm;
                s_in_valid = 1'b1;
                cyc();
                s_in_valid = 1'b0;
                checks++;
                if (pass == 0 && i == 3) begin
                    if (s_imem_we !== 1'b0 || s_err !== 1'b1 || s_count !== 3'd3 ||
                        s_in_ready !== 1'b0 || s_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL overflow: got we=%b err=%b count=%0d rdy=%b expected 0 1 3 0",
                                 s_imem_we, s_err, s_count, s_in_ready);
                    end
                end else if (s_imem_we !== 1'b1 || s_imem_addr !== 2'(i) ||
                             s_imem_wdata !== ref_word(s_in_kind, 5'(i + 1), 5'd0, 5'd0,
                                                        3'd0, 1'b0, imm)) begin
                    errors++;
                    $display("FAIL small_write%0d: got we=%b addr=%0d data=%h expected 1 %0d",
                             i, s_imem_we, s_imem_addr, s_imem_wdata, i);
                end
            end
        end
        checks++;
        if (s_done !== 1'b1 || s_err !== 1'b0 || s_count !== 3'd4 || s_imem_wdata !== 32'h7F) begin
            errors++;
            $display("FAIL halt_last_slot: got done=%b err=%b count=%0d data=%h expected 1 0 4 7f",
                     s_done, s_err, s_count, s_imem_wdata);
        end
    endtask

    task automatic test_start_collision();
        logic [31:0] w;
        do_start();
        beat(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, w);
        beat(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2, w);
        start = 1'b1;
        in_valid = 1'b1;
        in_kind = 4'd1; in_rd = 5'd9; in_imm = 32'd3;
        cyc();
        start = 1'b0;
        in_valid = 1'b0;
        m_count = 0; m_loading = 1'b1; m_done = 1'b0; m_err = 1'b0;
        checks++;
        if (imem_we !== 1'b0 || count !== 9'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_wins: got we=%b count=%0d rdy=%b expected 0 0 1",
                     imem_we, count, in_ready);
        end
        beat(4'd1, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4, w);
        // Reset with a beat offered in the same cycle.
        in_kind = 4'd1; in_rd = 5'd6; in_imm = 32'd8;
        in_valid = 1'b1;
        rst_n = 1'b0;
        cyc();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, imem_we, busy, done, err} !== 5'b0 || imem_addr !== 8'd0 ||
            imem_wdata !== 32'd0 || count !== 9'd0) begin
            errors++;
            $display("FAIL midload_reset: got flags=%b addr=%h data=%h count=%0d expected all 0",
                     {in_ready, imem_we, busy, done, err}, imem_addr, imem_wdata, count);
        end
        rst_n = 1'b1;
        m_count = 0; m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0;
        beat(4'd1, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, w);
    endtask

    task automatic test_range();
        logic [31:0] w;
        do_start();
        beat(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, w);
        checks++;
`ifdef IMEM_ENC_RANGE_CHECK_EN
        if (err !== 1'b1 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL range_branch: got err=%b we=%b expected 1 0", err, imem_we);
        end
`else
        if (w !== 32'h0020_8163 || err !== 1'b0) begin
            errors++;
            $display("FAIL trunc_branch: got %h err=%b expected 00208163 0", w, err);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] w, imm;
        logic [3:0]  k;
        int          n;
        for (int r = 0; r < 6; r++) begin
            do_start();
            n = $urandom_range(4, 40);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    cyc();
                    checks++;
                    if (imem_we !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_no_write: got we=%b expected 0", imem_we);
                    end
                end
                if ($urandom_range(0, 29) == 0) k = 4'($urandom_range(9, 15));
                else                            k = 4'($urandom_range(0, 7));
                case (k)
                    4'd4:    imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                    4'd5:    imm = $urandom() & 32'hFFFF_F000;
                    4'd6:    imm = 32'((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
                    default: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                endcase
`ifndef IMEM_ENC_RANGE_CHECK_EN
                if ($urandom_range(0, 1) == 0) imm = $urandom();
`endif
                beat(k, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
                     1'($urandom()), imm, w);
            end
            beat(4'd8, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, w);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_overflow();
        test_start_collision();
        test_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
